matrix_stream_buffer: RTL and testbench
=======================================

# matrix_stream_buffer

- Parametrised ROWS×COLS matrix store of DATA_W-bit elements, built from flops, for the matrix-multiplication datapath.
- Loaded one element per cycle through a (row, col) write port.
- Read either as a full flat snapshot or as a single row or column streamed element-by-element over a valid/ready handshake, so the multiplier can take A rows and B columns from the same block type.
- Single-cycle clear for back-to-back operand loads.

## Interface
- ROWS, default 10, number of matrix rows (≥2)
- COLS, default 10, number of matrix columns (≥2)
- DATA_W, default 8, element width in bits
- RW = $clog2(ROWS), CW = $clog2(COLS), IW = max(RW, CW); localparams
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  zero every element
- wr_en  in  1  write strobe
- wr_row  in  RW  write row index
- wr_col  in  CW  write column index
- wr_data  in  DATA_W  write data
- snap_en  in  1  capture whole matrix into all_data
- all_data  out  ROWS*COLS*DATA_W  element (r,c) at bits [(r*COLS+c)*DATA_W +: DATA_W]
- rd_start  in  1  start a stream
- rd_dir  in  1  0 = stream row rd_sel, 1 = stream column rd_sel
- rd_sel  in  IW  row or column index
- busy  out  1  stream in progress
- rd_err  out  1  one-cycle pulse: rejected rd_start
- out_valid  out  1  out_data holds a beat
- out_ready  in  1  consumer accepts beat
- out_data  out  DATA_W  current element
- out_last  out  1  current beat is final element

## Operation
- Reset (rst_n low, asynchronous): every element, all_data, out_data = 0; busy, out_valid, out_last, rd_err = 0; FSM = IDLE.
- Write: wr_en with wr_row<ROWS and wr_col<COLS updates element at the edge. Out-of-range writes are silently dropped.
- Clear: clr zeroes all elements at the edge. It has priority over a same-cycle write.
- Snapshot: snap_en registers the current memory contents (pre-edge values) into all_data. all_data holds otherwise. It is unaffected by clr until the next snap_en.
- FSM IDLE:
  - rd_start with rd_sel in range (<ROWS for row, <COLS for column) → STREAM.
  - Latch dir and sel, set beat counter = 0, load element 0 into out_data, set out_valid = 1.
  - rd_start with rd_sel out of range → rd_err pulse, stay IDLE.
- FSM STREAM:
  - busy = 1.
  - Beat transfers on out_valid && out_ready. On a non-final transfer, the counter increments and the next element loads into out_data at the same edge.
  - Element order: row streams c = 0..COLS-1; column streams r = 0..ROWS-1.
  - out_last = 1 while counter = LEN-1, where LEN = COLS for a row and ROWS for a column.
  - Transfer with out_last → IDLE: out_valid, out_last, busy = 0; out_data holds its last value.
  - With out_valid high and out_ready low, out_data and out_last stay stable.
  - rd_start during STREAM is ignored, with no rd_err.
- Element fetch is read-before-write: a beat loaded at the same edge as a write or clr to that element carries the old value. Beats loaded later see the new contents.
- Reset mid-stream aborts immediately to reset values.

## Timing
- Write/clr visible to a stream fetch or snap_en one cycle after the edge that performs it.
- snap_en at edge k → all_data valid after edge k.
- rd_start accepted at edge k → out_valid = 1, element 0 after edge k. With out_ready held high, one beat per cycle; LEN beats complete at edge k+LEN.
- busy falls after the final transfer edge. The next rd_start is accepted no earlier than the following edge, so there is one idle cycle between streams.
- rd_err is high exactly the cycle after the rejected rd_start edge.

## Test plan
- Reset values: reset, write (r,c) = r*10+c for all 100 elements, snap_en → all_data[7:0] = 0, bits [8*99 +: 8] = 99, element (3,7) = 37. Then assert rst_n low asynchronously mid-cycle → all outputs 0 immediately; a subsequent snapshot is all zeros.
- Row stream: same fill, rd_start rd_dir=0 rd_sel=4, out_ready = 1 → beats 40..49 on ten consecutive cycles, out_last only on 49, busy low after.
- Column stream with backpressure: rd_dir=1 rd_sel=2, out_ready toggling 1/0 → beats 2,12,…,92 in order, each held stable while out_ready = 0, out_last on 92.
- Hazards:
  - During a row-0 stream, write (0,5) = 0xAA on the edge element 5 loads → beat 5 = 5.
  - Write (0,6) = 0xBB two cycles earlier → beat 6 = 0xBB.
  - clr mid-stream → remaining beats 0.
- Rejection: rd_start rd_sel = 10 → rd_err one cycle, busy stays 0. rd_start during a stream → ignored. wr_row = 12 → memory unchanged. clr + wr_en same cycle → element = 0.
- Parameter sweep: ROWS=3, COLS=5, DATA_W=16 → row stream 5 beats, column stream 3 beats, all_data width 240, values match reference model.

Source files
------------

// File: rtl/matrix_stream_buffer.sv
// ---------------------------------------------------------------------------
// matrix_stream_buffer
// Flop-based ROWS x COLS matrix store of DATA_W-bit elements for the matrix
// multiplication datapath. It is loaded one element per cycle. It can be read
// as a full flat snapshot, or as one row or one column streamed beat-by-beat
// over a valid/ready handshake, so A rows and B columns use the same block.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clr        in   zero every element (wins over a same-cycle write)
//   wr_en      in   write strobe; out-of-range (wr_row, wr_col) is dropped
//   wr_row     in   [RW]      write row index
//   wr_col     in   [CW]      write column index
//   wr_data    in   [DATA_W]  write data
//   snap_en    in   capture the whole matrix into all_data
//   all_data   out  [ROWS*COLS*DATA_W]  element (r,c) at (r*COLS+c)*DATA_W
//   rd_start   in   start a stream
//   rd_dir     in   0 = stream row rd_sel, 1 = stream column rd_sel
//   rd_sel     in   [IW]      row or column index
//   busy       out  stream in progress
//   rd_err     out  one-cycle pulse for a rejected rd_start
//   out_valid  out  out_data holds a beat
//   out_ready  in   consumer accepts the beat
//   out_data   out  [DATA_W]  current element
//   out_last   out  current beat is the final element
// ---------------------------------------------------------------------------
module matrix_stream_buffer #(
    parameter  int ROWS   = 10,
    parameter  int COLS   = 10,
    parameter  int DATA_W = 8,
    localparam int RW     = $clog2(ROWS),
    localparam int CW     = $clog2(COLS),
    localparam int IW     = (RW > CW) ? RW : CW
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          wr_en,
    input  logic [RW-1:0]                 wr_row,
    input  logic [CW-1:0]                 wr_col,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          snap_en,
    output logic [ROWS*COLS*DATA_W-1:0]   all_data,
    input  logic                          rd_start,
    input  logic                          rd_dir,
    input  logic [IW-1:0]                 rd_sel,
    output logic                          busy,
    output logic                          rd_err,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_last
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    logic [DATA_W-1:0]           r_mem [ROWS][COLS];
    logic [ROWS*COLS*DATA_W-1:0] w_flat;
    logic [ROWS*COLS*DATA_W-1:0] r_all_data;

    state_t                      r_state, w_state_nxt;
    logic                        r_dir, w_dir_nxt;
    logic [IW-1:0]               r_sel, w_sel_nxt;
    logic [IW-1:0]               r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]           r_data, w_data_nxt;
    logic                        r_valid, w_valid_nxt;
    logic                        r_last, w_last_nxt;
    logic                        r_busy, w_busy_nxt;
    logic                        r_err, w_err_nxt;

    logic                        w_wr_hit;
    logic                        w_sel_ok;
    logic                        w_fetch_dir;
    logic [IW-1:0]               w_fetch_sel;
    logic [IW-1:0]               w_fetch_idx;
    logic [IW-1:0]               w_fetch_row;
    logic [IW-1:0]               w_fetch_col;
    logic [DATA_W-1:0]           w_fetch;
    logic [31:0]                 w_last_idx;

    // Range checks are done on zero-extended indices so that power-of-two
    // dimensions (where the index width cannot hold ROWS/COLS) still work.
    assign w_wr_hit = wr_en && (32'(wr_row) < 32'(ROWS)) && (32'(wr_col) < 32'(COLS));
    assign w_sel_ok = rd_dir ? (32'(rd_sel) < 32'(COLS)) : (32'(rd_sel) < 32'(ROWS));
    assign w_last_idx = r_dir ? 32'(ROWS - 1) : 32'(COLS - 1);

    // Element storage: clear has priority over a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_mem[r][c] <= '0;
                end
            end
        end else if (clr) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_mem[r][c] <= '0;
                end
            end
        end else if (w_wr_hit) begin
            r_mem[wr_row][wr_col] <= wr_data;
        end
    end

    // Flatten the array into the snapshot layout.
    always_comb begin
        w_flat = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                w_flat[(r*COLS+c)*DATA_W +: DATA_W] = r_mem[r][c];
            end
        end
    end

    // Snapshot register: holds until the next snap_en, clr does not touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_all_data <= '0;
        end else if (snap_en) begin
            r_all_data <= w_flat;
        end
    end

    // Element fetch from pre-edge contents: element 0 of the requested
    // line when idle, otherwise the element after the current beat.
    always_comb begin
        w_fetch_dir = r_dir;
        w_fetch_sel = r_sel;
        w_fetch_idx = r_cnt + IW'(1);
        if (r_state == ST_IDLE) begin
            w_fetch_dir = rd_dir;
            w_fetch_sel = rd_sel;
            w_fetch_idx = '0;
        end else begin
            w_fetch_dir = r_dir;
            w_fetch_sel = r_sel;
            w_fetch_idx = r_cnt + IW'(1);
        end
        w_fetch_row = w_fetch_dir ? w_fetch_idx : w_fetch_sel;
        w_fetch_col = w_fetch_dir ? w_fetch_sel : w_fetch_idx;
        if ((32'(w_fetch_row) < 32'(ROWS)) && (32'(w_fetch_col) < 32'(COLS))) begin
            w_fetch = r_mem[w_fetch_row[RW-1:0]][w_fetch_col[CW-1:0]];
        end else begin
            w_fetch = '0;
        end
    end

    // Stream FSM next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_busy_nxt  = r_busy;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rd_start) begin
                    if (w_sel_ok) begin
                        w_state_nxt = ST_STREAM;
                        w_dir_nxt   = rd_dir;
                        w_sel_nxt   = rd_sel;
                        w_cnt_nxt   = '0;
                        w_data_nxt  = w_fetch;
                        w_valid_nxt = 1'b1;
                        // Every line has at least two elements.
                        w_last_nxt  = 1'b0;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
                end else begin
                    w_err_nxt = 1'b0;
                end
            end
            ST_STREAM: begin
                if (r_valid && out_ready) begin
                    if (r_last) begin
                        w_state_nxt = ST_IDLE;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt   = r_cnt + IW'(1);
                        w_data_nxt  = w_fetch;
                        w_last_nxt  = ((32'(r_cnt) + 32'd1) == w_last_idx);
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Stream FSM state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_dir   <= 1'b0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign all_data  = r_all_data;
    assign busy      = r_busy;
    assign rd_err    = r_err;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_last  = r_last;

endmodule

// File: tb/tb_matrix_stream_buffer.sv
// ---------------------------------------------------------------------------
// tb_matrix_stream_buffer
// Directed bench for matrix_stream_buffer: a default 10x10x8 instance and a
// 3x5x16 instance, with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_matrix_stream_buffer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // 10x10x8 instance
    logic         a_clr, a_wr_en, a_snap, a_start, a_dir, a_ready;
    logic [3:0]   a_wr_row, a_wr_col, a_sel;
    logic [7:0]   a_wr_data, a_data;
    logic [799:0] a_all;
    logic         a_busy, a_err, a_valid, a_last;

    // 3x5x16 instance
    logic         b_clr, b_wr_en, b_snap, b_start, b_dir, b_ready;
    logic [1:0]   b_wr_row;
    logic [2:0]   b_wr_col, b_sel;
    logic [15:0]  b_wr_data, b_data;
    logic [239:0] b_all;
    logic         b_busy, b_err, b_valid, b_last;

    int n_checks = 0;
    int n_errors = 0;

    matrix_stream_buffer u_dut_a (
        .clk(clk), .rst_n(rst_n), .clr(a_clr), .wr_en(a_wr_en),
        .wr_row(a_wr_row), .wr_col(a_wr_col), .wr_data(a_wr_data),
        .snap_en(a_snap), .all_data(a_all), .rd_start(a_start),
        .rd_dir(a_dir), .rd_sel(a_sel), .busy(a_busy), .rd_err(a_err),
        .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data),
        .out_last(a_last)
    );

    matrix_stream_buffer #(.ROWS(3), .COLS(5), .DATA_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clr(b_clr), .wr_en(b_wr_en),
        .wr_row(b_wr_row), .wr_col(b_wr_col), .wr_data(b_wr_data),
        .snap_en(b_snap), .all_data(b_all), .rd_start(b_start),
        .rd_dir(b_dir), .rd_sel(b_sel), .busy(b_busy), .rd_err(b_err),
        .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
        .out_last(b_last)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] a_elem(input int r, input int c);
        return a_all[(r*10+c)*8 +: 8];
    endfunction

    function automatic logic [15:0] b_elem(input int r, input int c);
        return b_all[(r*5+c)*16 +: 16];
    endfunction

    task automatic a_write(input int r, input int c, input logic [7:0] d);
        a_wr_en = 1'b1; a_wr_row = 4'(r); a_wr_col = 4'(c); a_wr_data = d;
        tick();
        a_wr_en = 1'b0;
    endtask

    task automatic a_snap_pulse();
        a_snap = 1'b1;
        tick();
        a_snap = 1'b0;
    endtask

    task automatic b_write(input int r, input int c, input logic [15:0] d);
        b_wr_en = 1'b1; b_wr_row = 2'(r); b_wr_col = 3'(c); b_wr_data = d;
        tick();
        b_wr_en = 1'b0;
    endtask

    task automatic b_snap_pulse();
        b_snap = 1'b1;
        tick();
        b_snap = 1'b0;
    endtask

    task automatic a_fill();
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 10; c++) begin
                a_write(r, c, 8'(r*10 + c));
            end
        end
    endtask

    initial begin
        logic [7:0] hz_exp [10];
        hz_exp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'hBB, 8'd7, 8'd0, 8'd0};

        rst_n = 1'b0;
        a_clr = 1'b0; a_wr_en = 1'b0; a_snap = 1'b0; a_start = 1'b0;
        a_dir = 1'b0; a_ready = 1'b0; a_wr_row = 4'd0; a_wr_col = 4'd0;
        a_sel = 4'd0; a_wr_data = 8'd0;
        b_clr = 1'b0; b_wr_en = 1'b0; b_snap = 1'b0; b_start = 1'b0;
        b_dir = 1'b0; b_ready = 1'b0; b_wr_row = 2'd0; b_wr_col = 3'd0;
        b_sel = 3'd0; b_wr_data = 16'd0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset values
        check_val("rst_all",   32'(|a_all), 32'd0);
        check_val("rst_busy",  32'(a_busy), 32'd0);
        check_val("rst_valid", 32'(a_valid), 32'd0);
        check_val("rst_last",  32'(a_last), 32'd0);
        check_val("rst_err",   32'(a_err), 32'd0);
        check_val("rst_data",  32'(a_data), 32'd0);

        // Fill and snapshot
        a_fill();
        a_snap_pulse();
        check_val("snap_e0",  32'(a_all[7:0]), 32'd0);
        check_val("snap_e99", 32'(a_all[8*99 +: 8]), 32'd99);
        check_val("snap_3_7", 32'(a_elem(3, 7)), 32'd37);
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 10; c++) begin
                check_val("snap_all", 32'(a_elem(r, c)), 32'(r*10 + c));
            end
        end

        // Row 4 stream, out_ready held high
        a_dir = 1'b0; a_sel = 4'd4; a_ready = 1'b1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_val("row_valid", 32'(a_valid), 32'd1);
            check_val("row_busy",  32'(a_busy), 32'd1);
            check_val("row_data",  32'(a_data), 32'(40 + i));
            check_val("row_last",  32'(a_last), (i == 9) ? 32'd1 : 32'd0);
            tick();
        end
        check_val("row_end_busy",  32'(a_busy), 32'd0);
        check_val("row_end_valid", 32'(a_valid), 32'd0);
        check_val("row_end_last",  32'(a_last), 32'd0);
        check_val("row_end_hold",  32'(a_data), 32'd49);

        // Column 2 stream with every other cycle stalled; a rd_start
        // arrives during one stall and must be ignored.
        a_dir = 1'b1; a_sel = 4'd2; a_ready = 1'b0; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_val("col_valid", 32'(a_valid), 32'd1);
            check_val("col_data",  32'(a_data), 32'(i*10 + 2));
            check_val("col_last",  32'(a_last), (i == 9) ? 32'd1 : 32'd0);
            a_ready = 1'b0;
            if (i == 3) begin
                a_start = 1'b1; a_dir = 1'b0; a_sel = 4'd0;
            end
            tick();
            a_start = 1'b0; a_dir = 1'b1; a_sel = 4'd2;
            check_val("col_stall_data", 32'(a_data), 32'(i*10 + 2));
            check_val("col_stall_last", 32'(a_last), (i == 9) ? 32'd1 : 32'd0);
            check_val("col_stall_err",  32'(a_err), 32'd0);
            check_val("col_stall_busy", 32'(a_busy), 32'd1);
            a_ready = 1'b1;
            tick();
        end
        a_ready = 1'b0;
        check_val("col_end_busy",  32'(a_busy), 32'd0);
        check_val("col_end_valid", 32'(a_valid), 32'd0);

        // Row 0 stream with writes and a clear racing the fetches
        a_dir = 1'b0; a_sel = 4'd0; a_ready = 1'b1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_val("hz_data", 32'(a_data), 32'(hz_exp[i]));
            if (i == 3) begin
                a_wr_en = 1'b1; a_wr_row = 4'd0; a_wr_col = 4'd6; a_wr_data = 8'hBB;
            end else if (i == 4) begin
                a_wr_en = 1'b1; a_wr_row = 4'd0; a_wr_col = 4'd5; a_wr_data = 8'hAA;
            end else if (i == 6) begin
                a_clr = 1'b1;
            end
            tick();
            a_wr_en = 1'b0; a_clr = 1'b0;
        end
        a_ready = 1'b0;
        check_val("hz_end_busy", 32'(a_busy), 32'd0);
        check_val("clr_keeps_snap_3_7", 32'(a_elem(3, 7)), 32'd37);
        check_val("clr_keeps_snap_0_5", 32'(a_elem(0, 5)), 32'd5);
        a_snap_pulse();
        check_val("clr_snap_zero", 32'(|a_all), 32'd0);

        // Rejected stream requests
        a_dir = 1'b0; a_sel = 4'd10; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check_val("rej_row_err",   32'(a_err), 32'd1);
        check_val("rej_row_busy",  32'(a_busy), 32'd0);
        check_val("rej_row_valid", 32'(a_valid), 32'd0);
        tick();
        check_val("rej_err_pulse", 32'(a_err), 32'd0);
        check_val("rej_busy_after", 32'(a_busy), 32'd0);
        a_dir = 1'b1; a_sel = 4'd11; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check_val("rej_col_err", 32'(a_err), 32'd1);

        // Out-of-range writes are dropped
        a_write(12, 3, 8'h55);
        a_write(1, 10, 8'h66);
        a_snap_pulse();
        check_val("oor_write_dropped", 32'(|a_all), 32'd0);

        // clr beats a same-cycle write
        a_write(2, 2, 8'h77);
        a_snap_pulse();
        check_val("wr_after_clr", 32'(a_elem(2, 2)), 32'h77);
        a_clr = 1'b1;
        a_write(2, 2, 8'h66);
        a_clr = 1'b0;
        a_snap_pulse();
        check_val("clr_wins", 32'(a_elem(2, 2)), 32'd0);

        // Asynchronous reset in the middle of a stream
        a_write(1, 1, 8'h11);
        a_snap_pulse();
        check_val("pre_rst_snap", 32'(a_elem(1, 1)), 32'h11);
        a_dir = 1'b0; a_sel = 4'd1; a_start = 1'b1;
        tick();
        a_start = 1'b0; a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        check_val("pre_rst_data", 32'(a_data), 32'h11);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_all",   32'(|a_all), 32'd0);
        check_val("arst_valid", 32'(a_valid), 32'd0);
        check_val("arst_busy",  32'(a_busy), 32'd0);
        check_val("arst_data",  32'(a_data), 32'd0);
        check_val("arst_last",  32'(a_last), 32'd0);
        rst_n = 1'b1;
        tick();
        a_snap_pulse();
        check_val("arst_snap_zero", 32'(|a_all), 32'd0);

        // 3x5x16 instance: fill with 0xA000 + r*256 + c
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 5; c++) begin
                b_write(r, c, 16'(32'hA000 + r*256 + c));
            end
        end
        b_snap_pulse();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 5; c++) begin
                check_val("b_snap", 32'(b_elem(r, c)), 32'hA000 + 32'(r*256 + c));
            end
        end

        b_dir = 1'b0; b_sel = 3'd1; b_ready = 1'b1; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_val("b_row_data", 32'(b_data), 32'hA100 + 32'(i));
            check_val("b_row_last", 32'(b_last), (i == 4) ? 32'd1 : 32'd0);
            tick();
        end
        check_val("b_row_end_busy", 32'(b_busy), 32'd0);
        tick();

        b_dir = 1'b1; b_sel = 3'd3; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("b_col_data", 32'(b_data), 32'hA003 + 32'(i*256));
            check_val("b_col_last", 32'(b_last), (i == 2) ? 32'd1 : 32'd0);
            tick();
        end
        check_val("b_col_end_busy", 32'(b_busy), 32'd0);
        b_ready = 1'b0;

        b_dir = 1'b0; b_sel = 3'd3; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check_val("b_rej_row", 32'(b_err), 32'd1);
        b_dir = 1'b1; b_sel = 3'd5; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check_val("b_rej_col", 32'(b_err), 32'd1);
        check_val("b_rej_busy", 32'(b_busy), 32'd0);
        b_dir = 1'b1; b_sel = 3'd4; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check_val("b_col4_ok_err",  32'(b_err), 32'd0);
        check_val("b_col4_ok_data", 32'(b_data), 32'hA004);

        b_write(3, 0, 16'hFFFF);
        b_snap_pulse();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 5; c++) begin
                check_val("b_oor_write", 32'(b_elem(r, c)), 32'hA000 + 32'(r*256 + c));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
